// File: rtl/bb_latch_cfg_writer.sv
// Latch-bank configuration writer: runs a setup -> open -> hold sequence per
// accepted word so transparent-high latches always capture stable data.
`timescale 1ns/1ps
module bb_latch_cfg_writer #(
  parameter int NUM_WORDS   = 8,
  parameter int WORD_W      = 16,
  parameter int ADDR_W      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
  parameter int GATE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 testmode,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [WORD_W-1:0]    wr_data,
  output logic                 wr_done,
  output logic                 wr_abort,
  output logic                 addr_err,
  input  logic                 err_clr,
  output logic [WORD_W-1:0]    lat_d,
  output logic [NUM_WORDS-1:0] lat_gn
);
  localparam int CNT_W = $clog2(GATE_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, SETUP, OPEN, HOLD} state_t;

  state_t               state;
  logic [ADDR_W-1:0]    addr_q;
  logic [CNT_W-1:0]     cnt;
  logic [NUM_WORDS-1:0] gate_sel;
  logic                 addr_bad;
  logic                 accept;

  assign wr_ready = (state == IDLE) && !testmode;
  assign accept   = wr_valid && wr_ready;

  // An out-of-range address decodes to no gate at all.
  always_comb begin
    gate_sel = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      gate_sel[i] = (addr_q == ADDR_W'(i));
    end
  end
  assign addr_bad = ~|gate_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      cnt      <= '0;
      lat_d    <= '0;
      lat_gn   <= '0;
      wr_done  <= 1'b0;
      wr_abort <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      if (state == SETUP && addr_bad) begin
        addr_err <= 1'b1;
      end else if (err_clr) begin
        addr_err <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            addr_q <= wr_addr;
            lat_d  <= wr_data;
            state  <= SETUP;
          end
        end
        SETUP: begin
          if (testmode) begin
            state    <= HOLD;
            wr_done  <= 1'b1;
            wr_abort <= 1'b1;
          end else begin
            state  <= OPEN;
            lat_gn <= gate_sel;
            cnt    <= CNT_W'(GATE_CYCLES - 1);
          end
        end
        OPEN: begin
          // testmode cuts the gate on the very next edge, even mid-count.
          if (testmode || cnt == '0) begin
            state    <= HOLD;
            lat_gn   <= '0;
            wr_done  <= 1'b1;
            wr_abort <= testmode;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          state    <= IDLE;
          wr_done  <= 1'b0;
          wr_abort <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bb_latch_cfg_writer.sv
// Bench for bb_latch_cfg_writer: two configurations share one stimulus stream
// and are compared every cycle against a phase-based reference model.
`timescale 1ns/1ps
module tb_bb_latch_cfg_writer;
  localparam int A_NW = 8;
  localparam int A_GC = 2;
  localparam int B_NW = 5;
  localparam int B_GC = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        testmode = 1'b0;
  logic        wr_valid = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        err_clr = 1'b0;

  logic        a_ready, a_done, a_abort, a_err;
  logic [15:0] a_d;
  logic [7:0]  a_gn;
  logic        b_ready, b_done, b_abort, b_err;
  logic [15:0] b_d;
  logic [4:0]  b_gn;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  bb_latch_cfg_writer #(.NUM_WORDS(A_NW), .WORD_W(16), .ADDR_W(3), .GATE_CYCLES(A_GC)) u_a (
    .clk(clk), .rst_n(rst_n), .testmode(testmode), .wr_valid(wr_valid), .wr_ready(a_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(a_done), .wr_abort(a_abort),
    .addr_err(a_err), .err_clr(err_clr), .lat_d(a_d), .lat_gn(a_gn));

  bb_latch_cfg_writer #(.NUM_WORDS(B_NW), .WORD_W(16), .ADDR_W(3), .GATE_CYCLES(B_GC)) u_b (
    .clk(clk), .rst_n(rst_n), .testmode(testmode), .wr_valid(wr_valid), .wr_ready(b_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(b_done), .wr_abort(b_abort),
    .addr_err(b_err), .err_clr(err_clr), .lat_d(b_d), .lat_gn(b_gn));

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Model: p = cycles since accept (0 = idle), end_p = cycle that carries wr_done.
  int          p     [2] = '{0, 0};
  int          end_p [2] = '{0, 0};
  int          m_addr[2] = '{0, 0};
  logic [15:0] m_d   [2] = '{16'h0, 16'h0};
  logic        m_err [2] = '{1'b0, 1'b0};
  logic        m_abt [2] = '{1'b0, 1'b0};

  function automatic int nw(int i);
    return (i == 0) ? A_NW : B_NW;
  endfunction

  function automatic int gc(int i);
    return (i == 0) ? A_GC : B_GC;
  endfunction

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      bit set_err;
      set_err = 1'b0;
      if (!rst_n) begin
        p[i] = 0; end_p[i] = 0; m_d[i] = '0; m_err[i] = 1'b0; m_abt[i] = 1'b0;
      end else begin
        if (p[i] == 0) begin
          if (wr_valid && !testmode) begin
            p[i] = 1; m_addr[i] = int'(wr_addr); m_d[i] = wr_data;
            end_p[i] = gc(i) + 2; m_abt[i] = 1'b0;
          end
        end else if (p[i] == end_p[i]) begin
          p[i] = 0;
        end else begin
          if (p[i] == 1 && m_addr[i] >= nw(i)) set_err = 1'b1;
          if (testmode) begin
            end_p[i] = p[i] + 1;
            m_abt[i] = 1'b1;
          end
          p[i]++;
        end
        if (set_err) m_err[i] = 1'b1;
        else if (err_clr) m_err[i] = 1'b0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic compare_all();
    logic [7:0]  gn [2];
    logic [15:0] d  [2];
    logic        dn [2];
    logic        ab [2];
    logic        er [2];
    logic        rd [2];
    gn[0] = a_gn; gn[1] = {3'b000, b_gn};
    d[0]  = a_d;  d[1]  = b_d;
    dn[0] = a_done;  dn[1] = b_done;
    ab[0] = a_abort; ab[1] = b_abort;
    er[0] = a_err;   er[1] = b_err;
    rd[0] = a_ready; rd[1] = b_ready;
    for (int i = 0; i < 2; i++) begin
      logic [7:0] egn;
      logic       edone;
      egn   = (p[i] >= 2 && p[i] < end_p[i] && m_addr[i] < nw(i)) ? 8'(1 << m_addr[i]) : 8'h00;
      edone = (p[i] != 0 && p[i] == end_p[i]);
      chk($sformatf("u%0d_lat_gn", i), 32'(gn[i]), 32'(egn));
      chk($sformatf("u%0d_onehot0", i), 32'($onehot0(gn[i])), 32'd1);
      chk($sformatf("u%0d_lat_d", i), 32'(d[i]), 32'(m_d[i]));
      chk($sformatf("u%0d_wr_done", i), 32'(dn[i]), 32'(edone));
      chk($sformatf("u%0d_wr_abort", i), 32'(ab[i]), 32'(edone && m_abt[i]));
      chk($sformatf("u%0d_addr_err", i), 32'(er[i]), 32'(m_err[i]));
      chk($sformatf("u%0d_wr_ready", i), 32'(rd[i]), 32'(p[i] == 0 && !testmode));
    end
  endtask

  initial forever begin
    @(negedge clk);
    compare_all();
  end

  // Returns at posedge+2 with both instances idle and no request pending.
  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    wr_valid = 1'b0; testmode = 1'b0; err_clr = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (a_ready && b_ready) ok = 1'b1;
      @(posedge clk); #2;
      if (ok) break;
    end
    chk("wait_idle_timeout", 32'(ok), 32'd1);
  endtask

  task automatic next_cycle();
    @(posedge clk); #2;
  endtask

  int acc[4];

  initial begin
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_lat_gn", 32'(a_gn), 32'h0);
    chk("rst_lat_d", 32'(a_d), 32'h0);
    chk("rst_ready", 32'(a_ready), 32'd1);
    chk("rst_addr_err", 32'(b_err), 32'd0);
    next_cycle();

    // Single write, addr 3 / 0xA5C3.
    wait_idle();
    wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 16'hA5C3;
    next_cycle();
    wr_valid = 1'b0;
    @(negedge clk);
    chk("w1_lat_d", 32'(a_d), 32'hA5C3);
    chk("w1_setup_gn", 32'(a_gn), 32'h0);
    chk("w1_ready_drop", 32'(a_ready), 32'd0);
    @(negedge clk);
    chk("w1_open1_gn", 32'(a_gn), 32'h08);
    @(negedge clk);
    chk("w1_open2_gn", 32'(a_gn), 32'h08);
    @(negedge clk);
    chk("w1_hold_gn", 32'(a_gn), 32'h0);
    chk("w1_done", 32'(a_done), 32'd1);
    chk("w1_abort", 32'(a_abort), 32'd0);
    @(negedge clk);
    chk("w1_ready_back", 32'(a_ready), 32'd1);
    next_cycle();

    // Back-to-back writes with wr_valid held high.
    wait_idle();
    wr_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bit got;
      got = 1'b0;
      wr_addr = 3'(k);
      wr_data = 16'($urandom);
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        if (a_ready) got = 1'b1;
        next_cycle();
        if (got) break;
      end
      chk("b2b_accept_timeout", 32'(got), 32'd1);
      acc[k] = cyc;
    end
    wr_valid = 1'b0;
    for (int k = 1; k < 4; k++) chk("b2b_spacing", 32'(acc[k] - acc[k-1]), 32'd5);

    // Out-of-range address on the 5-word instance.
    wait_idle();
    wr_valid = 1'b1; wr_addr = 3'd5; wr_data = 16'h1234;
    next_cycle();
    wr_valid = 1'b0;
    @(negedge clk);
    chk("err_before_open", 32'(b_err), 32'd0);
    @(negedge clk);
    chk("err_set", 32'(b_err), 32'd1);
    chk("err_b_gn", 32'(b_gn), 32'h0);
    chk("err_a_gn", 32'(a_gn), 32'h20);
    next_cycle();
    wait_idle();
    @(negedge clk);
    chk("err_sticky", 32'(b_err), 32'd1);
    next_cycle();
    err_clr = 1'b1;
    next_cycle();
    err_clr = 1'b0;
    @(negedge clk);
    chk("err_cleared", 32'(b_err), 32'd0);
    next_cycle();
    wr_valid = 1'b1; wr_addr = 3'd6;
    next_cycle();
    wr_valid = 1'b0; err_clr = 1'b1;
    next_cycle();
    err_clr = 1'b0;
    @(negedge clk);
    chk("err_set_beats_clr", 32'(b_err), 32'd1);
    next_cycle();

    // testmode raised in the first open cycle.
    wait_idle();
    wr_valid = 1'b1; wr_addr = 3'd1; wr_data = 16'h5A5A;
    next_cycle();
    wr_valid = 1'b0;
    next_cycle();
    testmode = 1'b1;
    @(negedge clk);
    chk("abt_open_gn", 32'(b_gn), 32'h02);
    @(negedge clk);
    chk("abt_gn_closed", 32'(b_gn), 32'h0);
    chk("abt_done", 32'(b_done), 32'd1);
    chk("abt_abort", 32'(b_abort), 32'd1);
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk("abt_ready_held", 32'(b_ready), 32'd0);
    end
    next_cycle();
    testmode = 1'b0;

    // testmode in idle blocks a pending request.
    wait_idle();
    testmode = 1'b1; wr_valid = 1'b1; wr_addr = 3'd2; wr_data = 16'hBEEF;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      chk("tm_idle_gn", 32'(a_gn), 32'h0);
      chk("tm_idle_ready", 32'(a_ready), 32'd0);
      next_cycle();
    end
    testmode = 1'b0;
    @(negedge clk);
    chk("tm_drop_ready", 32'(a_ready), 32'd1);
    next_cycle();
    wr_valid = 1'b0;
    @(negedge clk);
    chk("tm_drop_accepted", 32'(a_d), 32'hBEEF);
    next_cycle();

    // Asynchronous reset in the middle of OPEN.
    wait_idle();
    wr_valid = 1'b1; wr_addr = 3'd4; wr_data = 16'hC0DE;
    next_cycle();
    wr_valid = 1'b0;
    next_cycle();
    chk("rst_mid_open_gn", 32'(a_gn), 32'h10);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_gn", 32'(a_gn), 32'h0);
    chk("rst_async_d", 32'(a_d), 32'h0);
    chk("rst_async_b_gn", 32'(b_gn), 32'h0);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_ready_a", 32'(a_ready), 32'd1);
    chk("rst_release_ready_b", 32'(b_ready), 32'd1);
    next_cycle();

    // Randomized traffic against the model.
    for (int t = 0; t < 400; t++) begin
      wr_valid = 1'($urandom_range(0, 1));
      wr_addr  = 3'($urandom_range(0, 7));
      wr_data  = 16'($urandom);
      testmode = ($urandom_range(0, 19) == 0);
      err_clr  = ($urandom_range(0, 9) == 0);
      next_cycle();
    end
    wait_idle();
    repeat (3) next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
